// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// reg_wb_arbiter: register-file writeback arbiter (ALU priority, ext FIFO,
// pending-register scoreboard). Optional macro: REG_WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_wr_valid,
    input  logic [ADDR_W-1:0]          alu_wr_addr,
    input  logic [DATA_W-1:0]          alu_wr_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic [ADDR_W-1:0]          ext_addr,
    input  logic [DATA_W-1:0]          ext_data,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_addr,
    input  logic [ADDR_W-1:0]          rd_addr_0,
    input  logic [ADDR_W-1:0]          rd_addr_1,
    output logic                       hazard,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [(2**ADDR_W)-1:0]     pending,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_waw
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [NREG-1:0]   r_pending;
    logic              r_err_waw;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_empty;
    logic              w_ready;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_ext_wr;
    logic [ADDR_W-1:0] w_ext_wr_addr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [NREG-1:0]   w_pending_nxt;

    assign w_empty = (r_count == '0);
    // Readiness comes from the registered count only, so a same-cycle pop
    // never opens a slot for a push.
    assign w_ready = (r_count != C_FULL);

`ifdef REG_WB_BYPASS_EN
    assign w_bypass = ~alu_wr_valid & w_empty & ext_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = ext_valid & w_ready & ~w_bypass;
    assign w_pop  = ~alu_wr_valid & ~w_empty;

    assign {w_head_addr, w_head_data} = r_mem[r_rd_ptr];

    assign w_ext_wr      = w_pop | w_bypass;
    assign w_ext_wr_addr = w_pop ? w_head_addr : ext_addr;

    // Set wins over clear when the same register is issued and retired together.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_ext_wr) begin
            w_pending_nxt[w_ext_wr_addr] = 1'b0;
        end
        if (issue_valid) begin
            w_pending_nxt[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ext_addr, ext_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_err_waw <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase

            r_pending <= w_pending_nxt;
            if (alu_wr_valid && r_pending[alu_wr_addr]) begin
                r_err_waw <= 1'b1;
            end

            if (alu_wr_valid) begin
                r_we    <= 1'b1;
                r_waddr <= alu_wr_addr;
                r_wdata <= alu_wr_data;
            end else if (w_pop) begin
                r_we    <= 1'b1;
                r_waddr <= w_head_addr;
                r_wdata <= w_head_data;
            end else if (w_bypass) begin
                r_we    <= 1'b1;
                r_waddr <= ext_addr;
                r_wdata <= ext_data;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    assign ext_ready    = w_ready;
    assign hazard       = r_pending[rd_addr_0] | r_pending[rd_addr_1];
    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;
    assign pending      = r_pending;
    assign fifo_count   = r_count;
    assign err_waw      = r_err_waw;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// ============================================================================
// tb_reg_wb_arbiter: scoreboard bench for reg_wb_arbiter; expected writes are
// queued by the stimulus and retired by a write monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wr_valid;
    logic [3:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        ext_valid;
    logic        ext_ready;
    logic [3:0]  ext_addr;
    logic [31:0] ext_data;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic [3:0]  rd_addr_0;
    logic [3:0]  rd_addr_1;
    logic        hazard;
    logic        write_enable;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [15:0] pending;
    logic [2:0]  fifo_count;
    logic        err_waw;

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_q [$];

    reg_wb_arbiter #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .ext_valid    (ext_valid),
        .ext_ready    (ext_ready),
        .ext_addr     (ext_addr),
        .ext_data     (ext_data),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .rd_addr_0    (rd_addr_0),
        .rd_addr_1    (rd_addr_1),
        .hazard       (hazard),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending      (pending),
        .fifo_count   (fifo_count),
        .err_waw      (err_waw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Write monitor: every register-file write must match the queue head.
    always @(negedge clk) begin
        if (write_enable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         write_addr, write_data);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({write_addr, write_data} !== e) begin
                    n_errors++;
                    $display("FAIL write_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             write_addr, write_data, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int acc;
        reset = 1'b1; alu_wr_valid = 0; alu_wr_addr = 0; alu_wr_data = 0;
        ext_valid = 0; ext_addr = 0; ext_data = 0;
        issue_valid = 0; issue_addr = 0; rd_addr_0 = 0; rd_addr_1 = 0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        at_neg();
        chk("rst_we",      {63'd0, write_enable}, 64'd0);
        chk("rst_waddr",   {60'd0, write_addr},   64'd0);
        chk("rst_wdata",   {32'd0, write_data},   64'd0);
        chk("rst_pending", {48'd0, pending},      64'd0);
        chk("rst_count",   {61'd0, fifo_count},   64'd0);
        chk("rst_err",     {63'd0, err_waw},      64'd0);
        chk("rst_ready",   {63'd0, ext_ready},    64'd1);

        // Single ALU write, visible for one cycle only
        tick();
        alu_wr_valid = 1; alu_wr_addr = 4'd1; alu_wr_data = 32'd39;
        exp_q.push_back({4'd1, 32'd39});
        tick();
        alu_wr_valid = 0;
        at_neg();
        chk("alu_we", {63'd0, write_enable}, 64'd1);
        chk("alu_pending", {48'd0, pending}, 64'd0);
        tick();

        // Issue then external result: scoreboard and hazard
        issue_valid = 1; issue_addr = 4'd2;
        tick();
        issue_valid = 0; rd_addr_0 = 4'd2;
        at_neg();
        chk("iss_pending", {48'd0, pending}, 64'h4);
        chk("iss_hazard",  {63'd0, hazard},  64'd1);
        tick();
        ext_valid = 1; ext_addr = 4'd2; ext_data = 32'hDEAD;
        exp_q.push_back({4'd2, 32'hDEAD});
        tick();
        ext_valid = 0;
        at_neg();
`ifdef REG_WB_BYPASS_EN
        chk("byp_pending", {48'd0, pending}, 64'd0);
        chk("byp_we",      {63'd0, write_enable}, 64'd1);
        tick();
`else
        chk("ext_we_n1",      {63'd0, write_enable}, 64'd0);
        chk("ext_pending_n1", {48'd0, pending}, 64'h4);
        chk("ext_hazard_n1",  {63'd0, hazard},  64'd1);
        chk("ext_count_n1",   {61'd0, fifo_count}, 64'd1);
        tick();
        at_neg();
        chk("ext_we_n2", {63'd0, write_enable}, 64'd1);
`endif
        chk("ext_pending_clr", {48'd0, pending}, 64'd0);
        chk("ext_hazard_clr",  {63'd0, hazard},  64'd0);
        rd_addr_0 = 0;
        tick();

        // Five ext results while ALU writes every cycle: FIFO fills at 4
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            alu_wr_valid = 1; alu_wr_addr = 4'd6; alu_wr_data = 32'd100 + 32'(c);
            exp_q.push_back({4'd6, 32'd100 + 32'(c)});
            ext_valid = 1; ext_addr = 4'(8 + acc); ext_data = 32'h1000 + 32'(acc);
            chk($sformatf("bp_ready_c%0d", c), {63'd0, ext_ready}, (c < 4) ? 64'd1 : 64'd0);
            if (ext_ready) acc++;
            tick();
        end
        for (int k = 0; k < 5; k++) exp_q.push_back({4'(8 + k), 32'h1000 + 32'(k)});
        chk("bp_accepts", 64'(acc), 64'd4);
        chk("bp_count",   {61'd0, fifo_count}, 64'd4);
        alu_wr_valid = 0;
        chk("bp_ready_pop", {63'd0, ext_ready}, 64'd0);
        tick();
        at_neg();
        chk("drain_count1", {61'd0, fifo_count}, 64'd3);
        chk("drain_ready1", {63'd0, ext_ready},  64'd1);
        tick();
        ext_valid = 0;
        repeat (4) tick();
        at_neg();
        chk("drain_count0", {61'd0, fifo_count}, 64'd0);
        tick();

        // ALU and ext together with empty FIFO: ALU first
        alu_wr_valid = 1; alu_wr_addr = 4'd3; alu_wr_data = 32'd7;
        ext_valid = 1; ext_addr = 4'd5; ext_data = 32'd9;
        exp_q.push_back({4'd3, 32'd7});
        exp_q.push_back({4'd5, 32'd9});
        tick();
        alu_wr_valid = 0; ext_valid = 0;
        at_neg();
        chk("both_first", {60'd0, write_addr}, 64'd3);
        tick();
        at_neg();
        chk("both_second", {60'd0, write_addr}, 64'd5);
        tick();

        // WAW: ALU writes a pending register
        issue_valid = 1; issue_addr = 4'd4;
        tick();
        issue_valid = 0;
        alu_wr_valid = 1; alu_wr_addr = 4'd4; alu_wr_data = 32'h44;
        exp_q.push_back({4'd4, 32'h44});
        tick();
        alu_wr_valid = 0; rd_addr_1 = 4'd4;
        at_neg();
        chk("waw_err",     {63'd0, err_waw}, 64'd1);
        chk("waw_pending", {48'd0, pending}, 64'h10);
        chk("waw_hazard1", {63'd0, hazard},  64'd1);
        repeat (2) tick();
        chk("waw_err_sticky", {63'd0, err_waw}, 64'd1);
        ext_valid = 1; ext_addr = 4'd4; ext_data = 32'h55;
        exp_q.push_back({4'd4, 32'h55});
        tick();
        ext_valid = 0;
        repeat (3) tick();
        chk("waw_pending_clr", {48'd0, pending}, 64'd0);
        chk("waw_err_hold",    {63'd0, err_waw}, 64'd1);
        rd_addr_1 = 0;

        // Reset with three entries buffered and a pending register
        issue_valid = 1; issue_addr = 4'd13;
        for (int c = 0; c < 3; c++) begin
            alu_wr_valid = 1; alu_wr_addr = 4'd0; alu_wr_data = 32'd200 + 32'(c);
            exp_q.push_back({4'd0, 32'd200 + 32'(c)});
            ext_valid = 1; ext_addr = 4'd14; ext_data = 32'h2000 + 32'(c);
            tick();
            issue_valid = 0;
        end
        alu_wr_valid = 0; ext_valid = 0;
        chk("pre_rst_count", {61'd0, fifo_count}, 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        chk("mrst_count",   {61'd0, fifo_count}, 64'd0);
        chk("mrst_pending", {48'd0, pending},    64'd0);
        chk("mrst_we",      {63'd0, write_enable}, 64'd0);
        chk("mrst_ready",   {63'd0, ext_ready},  64'd1);
        chk("mrst_err",     {63'd0, err_waw},    64'd0);
        repeat (5) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
